// File: rtl/z16_pkg.sv
// Shared Z16 CPU definitions: datapath widths, PC increment and the fetch entry layout.
package z16_pkg;

  localparam int          Z16_XLEN        = 16;
  localparam int          Z16_INSTR_BYTES = 2;
  localparam logic [15:0] Z16_PC_INC      = 16'd2;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } fetch_entry_t;

  localparam int Z16_ENTRY_W = $bits(fetch_entry_t);

  // Instructions are halfword aligned, so bit 0 of any fetch address is forced low.
  function automatic logic [15:0] z16_align(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/z16_fetch_fifo.sv
// Small registered FIFO holding fetched {pc, instr} pairs between fetch and decode.
// The read data is taken straight from storage; masking of empty reads is left to the user.
module z16_fetch_fifo
  import z16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          clear_i,
  input  logic [Z16_ENTRY_W-1:0]        data_i,
  output logic [Z16_ENTRY_W-1:0]        data_o,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the concurrent push lands in when full, so push is allowed then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state for pointers and occupancy; clear empties the FIFO outright.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset because occupancy gates their visibility.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= fetch_entry_t'(data_i);
    end
  end

endmodule

// File: rtl/z16_fetch_unit.sv
// Z16 instruction fetch: owns the PC, addresses the combinational instruction memory,
// queues {pc, instr} pairs for decode and handles flushing redirects from execute.
module z16_fetch_unit
  import z16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_imem_addr,
  input  logic [15:0] i_imem_instr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  output logic        o_misalign
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [15:0]             pc_q, pc_d;
  logic                    misalign_q, misalign_d;
  logic                    pop;
  logic                    push;
  logic [Z16_ENTRY_W-1:0]  fifo_wdata;
  logic [Z16_ENTRY_W-1:0]  fifo_rdata;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  fetch_entry_t            head;

  assign o_imem_addr = pc_q;
  assign o_misalign  = misalign_q;

  assign head    = fetch_entry_t'(fifo_rdata);
  assign o_valid = (fifo_count != '0);
  assign o_instr = fifo_empty ? 16'h0000 : head.instr;
  assign o_pc    = fifo_empty ? 16'h0000 : head.pc;

  // A redirect both suppresses the fetch and flushes the queue; any same-cycle pop is moot.
  assign pop        = o_valid & i_ready;
  assign push       = ~i_redirect & (~fifo_full | pop);
  assign fifo_wdata = {pc_q, i_imem_instr};

  // Next PC: redirect target wins, otherwise advance only when the fetched word is queued.
  always_comb begin
    pc_d       = pc_q;
    misalign_d = i_redirect & i_redirect_pc[0];
    if (i_redirect) begin
      pc_d = z16_align(i_redirect_pc);
    end else if (push) begin
      pc_d = pc_q + Z16_PC_INC;
    end
  end

  // PC and misalignment flag registers; reset overrides redirect and backpressure.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  z16_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_ni  (i_rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (i_redirect),
    .data_i  (fifo_wdata),
    .data_o  (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: doc/z16_fetch_unit.md
Name: z16_fetch_unit

Overview:
- Instruction-fetch stage of the Z16 CPU, sitting directly upstream of the combinational instruction memory.
- Owns the program counter and drives the memory byte address; the memory returns a 16-bit instruction in the same cycle.
- Captures {pc, instr} pairs into a small FIFO and hands them to decode with a valid/ready handshake.
- Accepts PC redirects from execute (taken branch or jump), which flush everything fetched so far.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset.
- o_imem_addr  out  16  byte address to instruction memory; always equals the PC register.
- i_imem_instr  in  16  instruction returned combinationally for o_imem_addr.
- o_valid  out  1  FIFO head holds a valid entry.
- i_ready  in  1  decode accepts the head this cycle.
- o_instr  out  16  head instruction.
- o_pc  out  16  byte address of the head instruction.
- i_redirect  in  1  taken branch/jump; flush and load the new PC.
- i_redirect_pc  in  16  redirect target byte address.
- o_misalign  out  1  one-cycle pulse: the redirect target had bit 0 set.

Behaviour:
- Reset (i_rst_n=0 at an edge):
  - pc=RESET_PC, FIFO empty, o_valid=0, o_misalign=0.
  - o_instr and o_pc read as 16'h0000 while the FIFO is empty.
  - Reset overrides every other input, including during a redirect or a full FIFO.
- Definitions:
  - pop = o_valid & i_ready.
  - push = !i_redirect & (count<DEPTH | pop).
- Push: at the edge, {pc, i_imem_instr} is written to the tail and pc <= pc+2.
- PC arithmetic: 16-bit, wrapping; 0xFFFE+2 = 0x0000. Bit 0 of pc is always 0.
- Latency: an instruction fetched in cycle N is visible at o_instr/o_pc in cycle N+1 at the earliest (registered FIFO). There is no combinational path from i_imem_instr to o_instr.
- Pop: the head advances at the edge. Push and pop in the same cycle are legal when full or empty-with-entry; count is unchanged when both occur.
- Full with no pop: no push, and pc holds.
- Redirect (i_redirect=1):
  - Highest priority after reset.
  - At the edge, the FIFO is cleared (count=0, o_valid=0 next cycle).
  - pc <= {i_redirect_pc[15:1], 1'b0}.
  - No push occurs that cycle; any pop that cycle is treated as consumed by decode.
  - The first redirected instruction appears at o_valid in the cycle after the one following the redirect (2-cycle bubble).
- o_misalign: registered, equals i_redirect & i_redirect_pc[0] from the previous cycle; it is 1 for exactly one cycle.
- Back-to-back redirects: each one simply reloads pc; the last one wins.
- Output stability: while o_valid=1 and i_ready=0, o_instr and o_pc remain stable (no change without a pop or redirect).
- State: an explicit two-state machine (RUN, FLUSH) is not required; the redirect-priority rules above are the complete control.

Decomposition:
- Shared package z16_pkg:
  - Z16_XLEN=16
  - Z16_INSTR_BYTES=2
  - Z16_PC_INC=16'd2
  - typedef fetch_entry_t {pc[15:0], instr[15:0]}
- One natural sub-module: z16_fetch_fifo.
  - Parameterised DEPTH.
  - Interface: push, pop, clear, data in/out, count, full, empty.
  - Synchronous active-low reset.
- The PC register and redirect logic stay in z16_fetch_unit.

Test Plan:
- Reset then i_ready=1 held, memory preloaded with 0x0010, 0x0020, 0x0A19: o_imem_addr is 0x0000, 0x0002, 0x0004 on successive cycles. o_valid first rises the cycle after reset release with o_pc=0x0000, o_instr=0x0010, followed by 0x0002/0x0020 and 0x0004/0x0A19 with no bubbles.
- Backpressure, i_ready=0 from reset: after 2 pushes, pc holds at 0x0004 and o_pc/o_instr hold 0x0000/0x0010. Raising i_ready for one cycle then dropping it gives o_pc=0x0002 and pc=0x0006.
- Redirect while full: i_redirect=1 with target 0x000A gives o_valid=0 next cycle and o_imem_addr=0x000A. The following cycle shows o_valid=1 and o_pc=0x000A. No stale 0x0000 or 0x0002 entry is ever presented.
- Misaligned redirect to 0x0007: pc becomes 0x0006, o_misalign=1 for exactly one cycle, and the first delivered o_pc is 0x0006.
- Wrap: with RESET_PC=0xFFFE, the fetch sequence is 0xFFFE then 0x0000, and o_pc shows 0xFFFE then 0x0000.
- Reset mid-stream: i_rst_n=0 asserted alongside a redirect and a full FIFO gives pc=RESET_PC, o_valid=0 and o_misalign=0 at the next edge. After release, the redirect target is ignored.
